hicore_commit: RTL
==================

HICORE_COMMIT -- requirements
Module: hicore_commit

Interface
REQ-001 SHALL have parameter XLEN, default 32: register, CSR-data and PC width.
REQ-002 SHALL have parameter RFIDX_W, default 5: register-file index width.
REQ-003 SHALL have parameter CSRIDX_W, default 12: CSR index width; WB info width is fixed at 8.
REQ-004 SHALL use one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports (name  direction  width  meaning), ROB side:
commit_valid  out  1  commit unit accepts head entry
commit_ready  in  1  head entry written back
commit_rd_need  in  1  entry writes rd
commit_rd_idx  in  RFIDX_W  rd index
commit_rd_data  in  XLEN  rd value
commit_csr_need  in  1  entry writes CSR
commit_csr_idx  in  CSRIDX_W  CSR index
commit_csr_data  in  XLEN  CSR value
commit_fence_i_op  in  1  entry is fence.i
commit_mret_op  in  1  entry is mret
commit_next_pc  in  XLEN  architectural next PC of entry
commit_info  in  8  [0] mispredict, [1] exception, [5:2] cause, [7:6] reserved
flush  out  1  one-cycle pipeline/ROB flush
REQ-006 SHALL have ports, core side:
redirect_valid  out  1  fetch redirect pulse
redirect_pc  out  XLEN  redirect target
rf_wen  out  1  register-file write strobe
rf_waddr  out  RFIDX_W  write index
rf_wdata  out  XLEN  write data
csr_wen  out  1  CSR write strobe
csr_waddr  out  CSRIDX_W  CSR write index
csr_wdata  out  XLEN  CSR write data
trap_valid  out  1  exception taken pulse
trap_cause  out  4  exception cause
trap_epc  out  XLEN  faulting PC
mret_valid  out  1  mret retired pulse
mtvec  in  XLEN  trap vector
mepc  in  XLEN  return PC
icache_inv_req  out  1  I-cache invalidate request
icache_inv_ack  in  1  invalidate complete

Function
REQ-007 SHALL implement states RUN, FENCEI, FLUSH; commit_valid = (state==RUN), combinational.
REQ-008 SHALL retire an entry ("fire") when commit_valid & commit_ready; at most one per cycle.
REQ-009 SHALL, one cycle after a non-exception fire with rd_need and rd_idx!=0, pulse rf_wen for one cycle with registered idx/data; rd_idx==0 SHALL never write.
REQ-010 SHALL, one cycle after a non-exception fire with csr_need, pulse csr_wen with registered idx/data.
REQ-011 SHALL classify a fire by priority exception > mret > fence.i > mispredict > normal.
REQ-012 Exception: no rf/csr write; next cycle pulse trap_valid, trap_cause=info[5:2], trap_epc=commit_next_pc-4 (mod 2^XLEN), flush, redirect_valid, redirect_pc=mtvec; state->FLUSH.
REQ-013 Mret: writes per REQ-009/010; next cycle pulse mret_valid, flush, redirect_valid, redirect_pc=mepc; state->FLUSH.
REQ-014 Mispredict: writes per REQ-009/010; next cycle pulse flush, redirect_valid, redirect_pc=commit_next_pc; state->FLUSH.
REQ-015 Fence.i: writes per REQ-009/010; latch commit_next_pc; state->FENCEI; icache_inv_req held high from next cycle until the cycle icache_inv_ack is sampled high; that cycle state->FLUSH and the following cycle flush/redirect pulse to latched PC.
REQ-016 FLUSH SHALL last exactly one cycle (pulses are high in it), then RUN; flush, redirect_valid, trap_valid, mret_valid are never high for more than one cycle.
REQ-017 icache_inv_ack outside FENCEI SHALL be ignored; ack in the same cycle the request first rises SHALL be honoured.
REQ-018 Normal fire SHALL stay in RUN; back-to-back fires SHALL sustain one retire per cycle.

Reset
REQ-019 On rst_n low, asynchronously: state=RUN; all strobes/pulses, icache_inv_req =0; data/index/pc outputs =0; latched PC =0; commit_valid=1 after release.
REQ-020 Reset asserted in FENCEI or FLUSH SHALL abort the operation with no pending pulse after release.

Verification
REQ-021 Normal: rd_need=1, idx=5, data=0xDEADBEEF, ready=1 -> next cycle rf_wen=1, waddr=5, wdata=0xDEADBEEF; no flush.
REQ-022 x0: rd_idx=0, csr_need=1, idx=0x300, data=0x8 -> rf_wen=0, csr_wen=1 waddr=0x300 wdata=0x8.
REQ-023 Exception: info=0x0A (cause 2), next_pc=0x104, mtvec=0x200 -> trap_valid, trap_cause=2, trap_epc=0x100, flush, redirect_pc=0x200; rf_wen=0; commit_valid low one cycle.
REQ-024 Fence.i: next_pc=0x80, ack after 3 cycles -> inv_req high 3 cycles, commit_valid low throughout, then flush+redirect_pc=0x80, then RUN.
REQ-025 Mispredict+mret together, mepc=0x40 -> mret wins: mret_valid, redirect_pc=0x40; reset asserted in FENCEI -> inv_req drops immediately, no redirect after release.

Source files
------------

// File: rtl/hicore_commit.sv
// rtl/hicore_commit.sv - in-order commit unit: retires ROB head, writes RF/CSR, raises traps, flushes and redirects
module hicore_commit #(
    parameter int XLEN     = 32,
    parameter int RFIDX_W  = 5,
    parameter int CSRIDX_W = 12
) (
    input  logic                clk,
    input  logic                rst_n,

    // ROB side
    output logic                commit_valid,
    input  logic                commit_ready,
    input  logic                commit_rd_need,
    input  logic [RFIDX_W-1:0]  commit_rd_idx,
    input  logic [XLEN-1:0]     commit_rd_data,
    input  logic                commit_csr_need,
    input  logic [CSRIDX_W-1:0] commit_csr_idx,
    input  logic [XLEN-1:0]     commit_csr_data,
    input  logic                commit_fence_i_op,
    input  logic                commit_mret_op,
    input  logic [XLEN-1:0]     commit_next_pc,
    input  logic [7:0]          commit_info,
    output logic                flush,

    // core side
    output logic                redirect_valid,
    output logic [XLEN-1:0]     redirect_pc,
    output logic                rf_wen,
    output logic [RFIDX_W-1:0]  rf_waddr,
    output logic [XLEN-1:0]     rf_wdata,
    output logic                csr_wen,
    output logic [CSRIDX_W-1:0] csr_waddr,
    output logic [XLEN-1:0]     csr_wdata,
    output logic                trap_valid,
    output logic [3:0]          trap_cause,
    output logic [XLEN-1:0]     trap_epc,
    output logic                mret_valid,
    input  logic [XLEN-1:0]     mtvec,
    input  logic [XLEN-1:0]     mepc,
    output logic                icache_inv_req,
    input  logic                icache_inv_ack
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_FENCEI = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    state_t                state_q;
    logic                  flush_q;
    logic                  redirect_valid_q;
    logic [XLEN-1:0]       redirect_pc_q;
    logic                  rf_wen_q;
    logic [RFIDX_W-1:0]    rf_waddr_q;
    logic [XLEN-1:0]       rf_wdata_q;
    logic                  csr_wen_q;
    logic [CSRIDX_W-1:0]   csr_waddr_q;
    logic [XLEN-1:0]       csr_wdata_q;
    logic                  trap_valid_q;
    logic [3:0]            trap_cause_q;
    logic [XLEN-1:0]       trap_epc_q;
    logic                  mret_valid_q;
    logic                  icache_inv_req_q;
    logic [XLEN-1:0]       fencei_pc_q;

    logic fire;
    logic is_exc;
    logic is_mret;
    logic is_fencei;
    logic is_mispred;
    logic rd_write;
    logic unused_info;

    // Entry classification; exception dominates, then mret, fence.i, mispredict
    assign commit_valid = (state_q == S_RUN);
    assign fire         = commit_valid & commit_ready;
    assign is_exc       = commit_info[1];
    assign is_mret      = ~is_exc & commit_mret_op;
    assign is_fencei    = ~is_exc & ~commit_mret_op & commit_fence_i_op;
    assign is_mispred   = ~is_exc & ~commit_mret_op & ~commit_fence_i_op & commit_info[0];
    assign rd_write     = commit_rd_need & (commit_rd_idx != '0);
    assign unused_info  = ^commit_info[7:6];

    // Commit FSM; every pulse output is a register cleared by default each cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_RUN;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            rf_wen_q         <= 1'b0;
            rf_waddr_q       <= '0;
            rf_wdata_q       <= '0;
            csr_wen_q        <= 1'b0;
            csr_waddr_q      <= '0;
            csr_wdata_q      <= '0;
            trap_valid_q     <= 1'b0;
            trap_cause_q     <= '0;
            trap_epc_q       <= '0;
            mret_valid_q     <= 1'b0;
            icache_inv_req_q <= 1'b0;
            fencei_pc_q      <= '0;
        end else begin
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            rf_wen_q         <= 1'b0;
            csr_wen_q        <= 1'b0;
            trap_valid_q     <= 1'b0;
            mret_valid_q     <= 1'b0;
            case (state_q)
                S_RUN: begin
                    if (fire) begin
                        if (!is_exc && rd_write) begin
                            rf_wen_q   <= 1'b1;
                            rf_waddr_q <= commit_rd_idx;
                            rf_wdata_q <= commit_rd_data;
                        end
                        if (!is_exc && commit_csr_need) begin
                            csr_wen_q   <= 1'b1;
                            csr_waddr_q <= commit_csr_idx;
                            csr_wdata_q <= commit_csr_data;
                        end
                        if (is_exc) begin
                            trap_valid_q     <= 1'b1;
                            trap_cause_q     <= commit_info[5:2];
                            trap_epc_q       <= commit_next_pc - XLEN'(4);
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= mtvec;
                            state_q          <= S_FLUSH;
                        end else if (is_mret) begin
                            mret_valid_q     <= 1'b1;
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= mepc;
                            state_q          <= S_FLUSH;
                        end else if (is_fencei) begin
                            fencei_pc_q      <= commit_next_pc;
                            icache_inv_req_q <= 1'b1;
                            state_q          <= S_FENCEI;
                        end else if (is_mispred) begin
                            flush_q          <= 1'b1;
                            redirect_valid_q <= 1'b1;
                            redirect_pc_q    <= commit_next_pc;
                            state_q          <= S_FLUSH;
                        end
                    end
                end
                S_FENCEI: begin
                    // Request stays up until the cache acknowledges, then flush to the latched PC
                    if (icache_inv_ack) begin
                        icache_inv_req_q <= 1'b0;
                        flush_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= fencei_pc_q;
                        state_q          <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    state_q <= S_RUN;
                end
                default: begin
                    state_q <= S_RUN;
                end
            endcase
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign rf_wen         = rf_wen_q;
    assign rf_waddr       = rf_waddr_q;
    assign rf_wdata       = rf_wdata_q;
    assign csr_wen        = csr_wen_q;
    assign csr_waddr      = csr_waddr_q;
    assign csr_wdata      = csr_wdata_q;
    assign trap_valid     = trap_valid_q;
    assign trap_cause     = trap_cause_q;
    assign trap_epc       = trap_epc_q;
    assign mret_valid     = mret_valid_q;
    assign icache_inv_req = icache_inv_req_q;

endmodule
